// File: rtl/tt_um_mac_accelerator_onsachinsharma.sv
// Byte-serial 8x8 multiply-accumulate tile: operand registers, product stage, 24-bit accumulator.
// Optional macro MAC_SATURATE_EN clamps the accumulator on signed overflow instead of wrapping.
module tt_um_mac_accelerator_onsachinsharma (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_ou,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_LOAD_A   = 3'b001,
    OP_LOAD_B   = 3'b010,
    OP_MAC      = 3'b011,
    OP_MAC_DATA = 3'b100,
    OP_CLEAR    = 3'b101,
    OP_MSUB     = 3'b110,
    OP_RSVD     = 3'b111
  } opcode_e;

  localparam logic [23:0] ACC_POS_MAX = 24'h7F_FFFF;
  localparam logic [23:0] ACC_NEG_MIN = 24'h80_0000;

  // Reset is active-high despite the pin name.
  logic [7:0]  a_q, b_q;
  logic [23:0] p_q;
  logic        pv_q, psub_q;
  logic [23:0] acc_q;
  logic        ovf_q;
  logic [3:0]  cnt_q;

  opcode_e     op;
  logic [1:0]  out_sel;
  logic        signed_mode;
  logic        issue;
  logic [7:0]  mul_b;
  logic [15:0] prod_s, prod_u;
  logic [23:0] prod_ext;
  logic [23:0] addend;
  logic [24:0] sum_wide;
  logic        ovf_now;
  logic [23:0] acc_next;
  logic        unused_bits;

  assign unused_bits = &{1'b0, uio_in[7:6]};
  assign out_sel     = uio_in[4:3];
  assign signed_mode = uio_in[5];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    op = OP_NOP;
    if (ena) op = opcode_e'(uio_in[2:0]);
  end

  assign issue = (op == OP_MAC) || (op == OP_MAC_DATA) || (op == OP_MSUB);
  assign mul_b = (op == OP_MAC_DATA) ? ui_in : b_q;

  // Both products are 16 bits wide; the mode picks which one is extended into P.
  assign prod_s   = $signed({{8{a_q[7]}}, a_q}) * $signed({{8{mul_b[7]}}, mul_b});
  assign prod_u   = {8'h00, a_q} * {8'h00, mul_b};
  assign prod_ext = signed_mode ? {{8{prod_s[15]}}, prod_s} : {8'h00, prod_u};

  // |P| never reaches 2^23, so negating it for MSUB cannot itself overflow.
  assign addend   = psub_q ? (24'd0 - p_q) : p_q;
  assign sum_wide = {acc_q[23], acc_q} + {addend[23], addend};
  assign ovf_now  = sum_wide[24] ^ sum_wide[23];

`ifdef MAC_SATURATE_EN
  always_comb begin
    acc_next = sum_wide[23:0];
    if (ovf_now) acc_next = sum_wide[24] ? ACC_NEG_MIN : ACC_POS_MAX;
  end
`else
  logic unused_limits;
  assign unused_limits = &{1'b0, ACC_POS_MAX, ACC_NEG_MIN};
  always_comb acc_next = sum_wide[23:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      p_q    <= 24'h00_0000;
      pv_q   <= 1'b0;
      psub_q <= 1'b0;
    end else begin
      if (op == OP_LOAD_A) a_q <= ui_in;
      if (op == OP_LOAD_B || op == OP_MAC_DATA) b_q <= ui_in;
      pv_q <= issue;
      if (issue) begin
        p_q    <= prod_ext;
        psub_q <= (op == OP_MSUB);
      end
    end
  end

  // Accumulate stage ignores ena so a product issued just before ena drops still retires.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_q <= 24'h00_0000;
      ovf_q <= 1'b0;
      cnt_q <= 4'd0;
    end else if (op == OP_CLEAR) begin
      acc_q <= 24'h00_0000;
      ovf_q <= 1'b0;
      cnt_q <= 4'd0;
    end else if (pv_q) begin
      acc_q <= acc_next;
      if (ovf_now) ovf_q <= 1'b1;
      if (cnt_q != 4'hF) cnt_q <= cnt_q + 4'd1;
    end
  end

  always_comb begin
    uo_out = acc_q[7:0];
    case (out_sel)
      2'b00:   uo_out = acc_q[7:0];
      2'b01:   uo_out = acc_q[15:8];
      2'b10:   uo_out = acc_q[23:16];
      default: uo_out = {ovf_q, pv_q, (acc_q == 24'd0), acc_q[23], cnt_q};
    endcase
  end

  assign uio_ou = 8'h00;
  assign uio_oe = 8'h00;

endmodule

// File: tb/tb_tt_um_mac_accelerator_onsachinsharma.sv
// Self-checking bench: integer-level MAC model checked every cycle, plus literal scenario checks.
// Build with MAC_SATURATE_EN defined to expect clamping instead of wrap-around.
module tb_tt_um_mac_accelerator_onsachinsharma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_ou, uio_oe;

  tt_um_mac_accelerator_onsachinsharma dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_ou(uio_ou), .uio_oe(uio_oe)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state kept as plain integers.
  int m_a = 0, m_b = 0, m_acc = 0, m_ovf = 0, m_cnt = 0, m_pv = 0, m_delta = 0;

  logic       sgn = 1'b0;
  logic [1:0] sel = 2'b00;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int s8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic logic [7:0] exp_out(input logic [1:0] s);
    logic [23:0] v;
    logic [3:0]  c;
    v = m_acc[23:0];
    c = m_cnt[3:0];
    case (s)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      2'd2:    return v[23:16];
      default: return {m_ovf[0], m_pv[0], (v == 24'd0), v[23], c};
    endcase
  endfunction

  task automatic model_step();
    int op, r, bval, v;
    op = ena ? int'(uio_in[2:0]) : 0;
    if (m_pv != 0 && op != 5) begin
      r = m_acc + m_delta;
      if (r > 8388607 || r < -8388608) begin
        m_ovf = 1;
`ifdef MAC_SATURATE_EN
        r = (r > 8388607) ? 8388607 : -8388608;
`else
        r = (r > 8388607) ? r - 16777216 : r + 16777216;
`endif
      end
      m_acc = r;
      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end
    if (op == 5) begin
      m_acc = 0; m_ovf = 0; m_cnt = 0;
    end
    bval = (op == 4) ? int'(ui_in) : m_b;
    if (op == 3 || op == 4 || op == 6) begin
      v = uio_in[5] ? s8(m_a) * s8(bval) : m_a * bval;
      m_delta = (op == 6) ? -v : v;
      m_pv = 1;
    end else begin
      m_pv = 0;
    end
    if (op == 1) m_a = int'(ui_in);
    if (op == 2 || op == 4) m_b = int'(ui_in);
  endtask

  initial forever begin
    @(posedge clk or posedge rst_n);
    if (rst_n) begin
      m_a = 0; m_b = 0; m_acc = 0; m_ovf = 0; m_cnt = 0; m_pv = 0; m_delta = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle compare, mid-cycle while inputs are stable.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check($sformatf("cycle_uo_sel%0d", uio_in[4:3]), uo_out, exp_out(uio_in[4:3]));
      check("cycle_uio_oe", uio_oe, 8'h00);
      check("cycle_uio_ou", uio_ou, 8'h00);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply(input logic [2:0] op, input logic [7:0] data, input logic en = 1'b1);
    @(negedge clk); #1;
    ena    = en;
    ui_in  = data;
    uio_in = {2'b00, sgn, sel, op};
  endtask

  task automatic expect_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    @(negedge clk); #1;
    ena = 1'b1;
    uio_in[2:0] = 3'b000;
    for (int s = 0; s < 4; s++) begin
      uio_in[4:3] = s[1:0];
      #1;
      check($sformatf("%s_sel%0d", tag, s), uo_out, (s == 0) ? e0 : (s == 1) ? e1 : (s == 2) ? e2 : e3);
    end
  endtask

  initial begin
    // Reset state.
    uio_in = 8'h18;
    #12;
    check("reset_status", uo_out, 8'h20);
    uio_in = 8'h00;
    #1;
    check("reset_byte0", uo_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_ou", uio_ou, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b0;

    // Unsigned MAC: 200 * 250 = 50000.
    sgn = 1'b0;
    apply(3'b001, 8'd200);
    apply(3'b010, 8'd250);
    apply(3'b011, 8'h00);
    apply(3'b000, 8'h00);
    expect_bytes("umac", 8'h50, 8'hC3, 8'h00, 8'h01);

    // Signed MAC: -2 * 3 = -6, then MSUB back to zero.
    sgn = 1'b1;
    apply(3'b101, 8'h00);
    apply(3'b001, 8'hFE);
    apply(3'b010, 8'h03);
    apply(3'b011, 8'h00);
    apply(3'b000, 8'h00);
    expect_bytes("smac", 8'hFA, 8'hFF, 8'hFF, 8'h11);
    apply(3'b110, 8'h00);
    apply(3'b000, 8'h00);
    expect_bytes("msub", 8'h00, 8'h00, 8'h00, 8'h22);

    // Streaming MAC_DATA: 3*(1+2+3+4) = 30.
    sgn = 1'b0;
    apply(3'b101, 8'h00);
    apply(3'b001, 8'd3);
    for (int i = 1; i <= 4; i++) apply(3'b100, 8'(i));
    apply(3'b000, 8'h00);
    expect_bytes("stream", 8'h1E, 8'h00, 8'h00, 8'h04);

    // Overflow: 512 x 16384 = 2^23.
    sgn = 1'b1;
    apply(3'b101, 8'h00);
    apply(3'b001, 8'h80);
    apply(3'b010, 8'h80);
    for (int i = 0; i < 512; i++) apply(3'b011, 8'h00);
    apply(3'b000, 8'h00);
`ifdef MAC_SATURATE_EN
    expect_bytes("ovf", 8'hFF, 8'hFF, 8'h7F, 8'h8F);
`else
    expect_bytes("ovf", 8'h00, 8'h00, 8'h80, 8'h9F);
`endif

    // CLEAR colliding with a retiring product.
    sgn = 1'b0;
    apply(3'b101, 8'h00);
    apply(3'b001, 8'd5);
    apply(3'b010, 8'd7);
    apply(3'b011, 8'h00);
    apply(3'b011, 8'h00);
    apply(3'b101, 8'h00);
    expect_bytes("clr_collide", 8'h00, 8'h00, 8'h00, 8'h20);

    // ena=0 turns CLEAR into NOP; the in-flight product retires anyway.
    apply(3'b011, 8'h00);
    apply(3'b101, 8'h00, 1'b0);
    expect_bytes("ena_low", 8'h23, 8'h00, 8'h00, 8'h01);

    // Reset asserted while a product is in flight.
    apply(3'b011, 8'h00);
    @(negedge clk); #1;
    uio_in = 8'h18;
    rst_n = 1'b1;
    #1;
    check("midrst_status", uo_out, 8'h20);
    #1;
    rst_n = 1'b0;
    expect_bytes("midrst_after", 8'h00, 8'h00, 8'h00, 8'h20);

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      sgn = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      apply(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
    end
    apply(3'b000, 8'h00);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
